// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and byte constants for the PS/2 key decoder
// Holds the prefix-parser state enum, PS/2 prefix/discard bytes,
// direction scancodes and the move encoding used by the decoder and tracker.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    // Prefix bytes
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;

    // Controller/keyboard status bytes that never form a key event
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ERR0   = 8'h00;
    localparam logic [7:0] CODE_ERR1   = 8'hFF;

    // Pause sends E1 followed by seven more bytes
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    // Direction scancodes: arrows are E0-prefixed, WASD are plain
    localparam logic [7:0] CODE_UP     = 8'h75;
    localparam logic [7:0] CODE_DOWN   = 8'h72;
    localparam logic [7:0] CODE_LEFT   = 8'h6B;
    localparam logic [7:0] CODE_RIGHT  = 8'h74;
    localparam logic [7:0] CODE_W      = 8'h1D;
    localparam logic [7:0] CODE_S      = 8'h1B;
    localparam logic [7:0] CODE_A      = 8'h1C;
    localparam logic [7:0] CODE_D      = 8'h23;

    // move encoding
    localparam logic [2:0] MOVE_NONE   = 3'd0;
    localparam logic [2:0] MOVE_UP     = 3'd1;
    localparam logic [2:0] MOVE_DOWN   = 3'd2;
    localparam logic [2:0] MOVE_LEFT   = 3'd3;
    localparam logic [2:0] MOVE_RIGHT  = 3'd4;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == CODE_EXT) || (b == CODE_BRK) || (b == CODE_PAUSE);
    endfunction

    function automatic logic is_discard(input logic [7:0] b);
        return (b == CODE_ACK) || (b == CODE_BAT) || (b == CODE_ECHO) ||
               (b == CODE_RESEND) || (b == CODE_ERR0) || (b == CODE_ERR1);
    endfunction

endpackage

// File: rtl/ps2_dir_tracker.sv
// rtl/ps2_dir_tracker.sv - held-state and last-direction tracking for direction keys
// Ports: clk, resetn (async, active-low); ev strobe with code/make/ext of the
// decoded event; held = {right, left, down, up}; move = last direction pressed.
module ps2_dir_tracker
    import ps2_pkg::*;
#(
    parameter bit WASD_EN = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ev,
    input  logic [7:0] code,
    input  logic       make,
    input  logic       ext,
    output logic [3:0] held,
    output logic [2:0] move
);

    logic       dir_hit;
    logic [1:0] dir_idx;
    logic [3:0] dir_bit;
    logic [2:0] dir_move;
    logic [3:0] held_next;
    logic [2:0] move_next;

    // Highest-priority held key: up > down > left > right
    function automatic logic [2:0] fallback(input logic [3:0] h);
        if (h[0])      return MOVE_UP;
        else if (h[1]) return MOVE_DOWN;
        else if (h[2]) return MOVE_LEFT;
        else if (h[3]) return MOVE_RIGHT;
        else           return MOVE_NONE;
    endfunction

    always_comb begin
        dir_hit = 1'b0;
        dir_idx = 2'd0;
        if (ext) begin
            case (code)
                CODE_UP:    begin dir_hit = 1'b1; dir_idx = 2'd0; end
                CODE_DOWN:  begin dir_hit = 1'b1; dir_idx = 2'd1; end
                CODE_LEFT:  begin dir_hit = 1'b1; dir_idx = 2'd2; end
                CODE_RIGHT: begin dir_hit = 1'b1; dir_idx = 2'd3; end
                default:    ;
            endcase
        end else if (WASD_EN) begin
            case (code)
                CODE_W:  begin dir_hit = 1'b1; dir_idx = 2'd0; end
                CODE_S:  begin dir_hit = 1'b1; dir_idx = 2'd1; end
                CODE_A:  begin dir_hit = 1'b1; dir_idx = 2'd2; end
                CODE_D:  begin dir_hit = 1'b1; dir_idx = 2'd3; end
                default: ;
            endcase
        end
    end

    assign dir_bit  = 4'b0001 << dir_idx;
    assign dir_move = {1'b0, dir_idx} + 3'd1;

    always_comb begin
        held_next = held;
        move_next = move;
        if (ev && dir_hit) begin
            if (make) begin
                held_next = held | dir_bit;
                move_next = dir_move;
            end else begin
                held_next = held & ~dir_bit;
                // Only the key currently steering hands over to a remaining one
                if (move == dir_move) begin
                    move_next = fallback(held_next);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held <= 4'd0;
            move <= MOVE_NONE;
        end else begin
            held <= held_next;
            move <= move_next;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 byte-stream to key-event decoder with direction tracking
// Ports: clk, resetn (async, active-low); key_en/key_data byte input;
// key_valid pulse with keycode/key_make/key_ext; held/move direction state;
// err pulse on malformed or timed-out prefix sequences.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = 2_500_000,
    parameter bit WASD_EN = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_en,
    input  logic [7:0] key_data,
    output logic       key_valid,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic [3:0] held,
    output logic [2:0] move,
    output logic       err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ps2_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       skip, skip_next;
    logic             ev;
    logic [7:0]       ev_code;
    logic             ev_make;
    logic             ev_ext;
    logic             err_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        skip_next  = skip;
        ev         = 1'b0;
        ev_code    = key_data;
        ev_make    = 1'b1;
        ev_ext     = 1'b0;
        err_next   = 1'b0;

        if (key_en) begin
            cnt_next = '0;
            case (state)
                ST_IDLE: begin
                    if (key_data == CODE_EXT) begin
                        state_next = ST_EXT;
                    end else if (key_data == CODE_BRK) begin
                        state_next = ST_BRK;
                    end else if (key_data == CODE_PAUSE) begin
                        state_next = ST_PAUSE;
                        skip_next  = PAUSE_SKIP;
                    end else if (!is_discard(key_data)) begin
                        ev = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (key_data == CODE_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (key_data != CODE_EXT) begin
                        ev         = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    if (is_prefix(key_data)) begin
                        err_next = 1'b1;
                    end else begin
                        ev      = 1'b1;
                        ev_make = 1'b0;
                        ev_ext  = (state == ST_EXT_BRK);
                    end
                end
                ST_PAUSE: begin
                    // Trailing Pause bytes are swallowed unparsed
                    skip_next = skip - 3'd1;
                    if (skip == 3'd1) begin
                        ev         = 1'b1;
                        ev_code    = CODE_PAUSE;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (cnt == CNT_LAST) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                skip_next  = 3'd0;
                err_next   = 1'b1;
            end else if (cnt != '1) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            skip      <= 3'd0;
            key_valid <= 1'b0;
            keycode   <= 8'd0;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            skip      <= skip_next;
            key_valid <= ev;
            err       <= err_next;
            if (ev) begin
                keycode  <= ev_code;
                key_make <= ev_make;
                key_ext  <= ev_ext;
            end
        end
    end

    ps2_dir_tracker #(
        .WASD_EN (WASD_EN)
    ) u_dir (
        .clk    (clk),
        .resetn (resetn),
        .ev     (ev),
        .code   (ev_code),
        .make   (ev_make),
        .ext    (ev_ext),
        .held   (held),
        .move   (move)
    );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_en = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_valid;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic [3:0] held;
    logic [2:0] move;
    logic       err;

    ps2_key_decoder #(
        .TIMEOUT (T),
        .WASD_EN (1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_en    (key_en),
        .key_data  (key_data),
        .key_valid (key_valid),
        .keycode   (keycode),
        .key_make  (key_make),
        .key_ext   (key_ext),
        .held      (held),
        .move      (move),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       mk;
        logic       ex;
        logic [3:0] hl;
        logic [2:0] mv;
    } exp_t;

    exp_t exp_q[$];
    int   exp_err = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_cyc = -1;

    // Reference model: pending-prefix flags and a held-key table
    bit   m_ext, m_brk;
    int   m_pause;
    bit   m_held[4];
    int   m_last;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dir_of(input logic [7:0] b, input bit ext);
        if (ext) begin
            if (b == 8'h75) return 0;
            if (b == 8'h72) return 1;
            if (b == 8'h6B) return 2;
            if (b == 8'h74) return 3;
        end else begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1B) return 1;
            if (b == 8'h1C) return 2;
            if (b == 8'h23) return 3;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_pause = 0;
    endtask

    task automatic emit(input logic [7:0] b, input bit mk, input bit ex);
        exp_t e;
        int d;
        d = dir_of(b, ex);
        if (d >= 0) begin
            if (mk) begin
                m_held[d] = 1;
                m_last = d + 1;
            end else begin
                m_held[d] = 0;
                if (m_last == d + 1) begin
                    m_last = 0;
                    for (int i = 0; i < 4; i++)
                        if (m_held[i] && m_last == 0) m_last = i + 1;
                end
            end
        end
        e.code = b; e.mk = mk; e.ex = ex;
        e.hl = {m_held[3], m_held[2], m_held[1], m_held[0]};
        e.mv = 3'(m_last);
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit pre;
        pre = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) emit(8'hE1, 1, 0);
        end else if (m_brk) begin
            if (pre) exp_err++;
            else emit(b, 0, m_ext);
            model_clear();
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                emit(b, 1, 1);
                model_clear();
            end
        end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE1) m_pause = 7;
            else if (!(b == 8'hFA || b == 8'hAA || b == 8'hEE ||
                       b == 8'hFE || b == 8'h00 || b == 8'hFF))
                emit(b, 1, 0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        key_data = b;
        key_en   = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        key_en   = 1'b0;
    endtask

    // Idle long enough for any pending prefix to time out
    task automatic flush();
        if (m_ext || m_brk || m_pause > 0) begin
            exp_err++;
            model_clear();
        end
        tick(2 * T + 4);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every DUT event/err against the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event_unexpected: got code=%0h make=%0b ext=%0b, no event expected",
                             keycode, key_make, key_ext);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (keycode !== e.code || key_make !== e.mk || key_ext !== e.ex ||
                        held !== e.hl || move !== e.mv) begin
                        errors++;
                        $display("FAIL event: got code=%0h make=%0b ext=%0b held=%b move=%0d expected code=%0h make=%0b ext=%0b held=%b move=%0d",
                                 keycode, key_make, key_ext, held, move,
                                 e.code, e.mk, e.ex, e.hl, e.mv);
                    end
                end
            end
            if (err) begin
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got err=1 expected 0");
                end else begin
                    exp_err--;
                    err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int e0_cyc;
        int r;
        logic [7:0] b;
        logic [7:0] dir_tab [8];
        logic [7:0] disc_tab [6];
        dir_tab  = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};
        disc_tab = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        model_clear();
        foreach (m_held[i]) m_held[i] = 0;
        m_last = 0;

        tick(3);
        check("rst_key_valid", key_valid, 0);
        check("rst_keycode", keycode, 0);
        check("rst_key_make", key_make, 0);
        check("rst_key_ext", key_ext, 0);
        check("rst_held", held, 0);
        check("rst_move", move, 0);
        check("rst_err", err, 0);
        resetn = 1'b1;
        tick(2);

        // WASD left make then release
        send(8'h1C); tick(2);
        send(8'hF0); send(8'h1C); tick(2);
        // Arrow up make / break
        send(8'hE0); send(8'h75); tick(2);
        send(8'hE0); send(8'hF0); send(8'h75); tick(2);
        // Up held, right press/release, up release: move 1 -> 4 -> 1 -> 0
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h74);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hE0); send(8'hF0); send(8'h75); tick(2);
        // Pause sequence back-to-back, then status bytes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'hFA); send(8'hAA); tick(2);
        // Malformed break
        send(8'hF0); send(8'hF0); tick(2);
        check("malformed_err_seen", exp_err, 0);

        // Timeout after lone E0, then plain byte
        send(8'hE0);
        e0_cyc = cyc;
        flush();
        check("timeout_err_seen", exp_err, 0);
        checks++;
        if (err_cyc - e0_cyc < T - 1 || err_cyc - e0_cyc > T + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d",
                     err_cyc - e0_cyc, T - 1, T + 1);
        end
        send(8'h1C); tick(2);

        // Reset mid-sequence
        send(8'hE0);
        #2 resetn = 1'b0;
        #1;
        check("midrst_keycode", keycode, 0);
        check("midrst_held", held, 0);
        check("midrst_move", move, 0);
        check("midrst_key_make", key_make, 0);
        model_clear();
        foreach (m_held[i]) m_held[i] = 0;
        m_last = 0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        send(8'h75); tick(2);

        // Randomized byte stream
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 15);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else if (r == 5) b = disc_tab[$urandom_range(0, 5)];
            else if (r < 12) b = dir_tab[$urandom_range(0, 7)];
            else             b = 8'($urandom_range(0, 255));
            send(b);
            tick($urandom_range(0, 3));
        end
        flush();

        check("queue_drained", exp_q.size(), 0);
        check("err_drained", exp_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
